csc_link_sync_mon: RTL and testbench

//  Parametrised successor of the CFEB sync monitor: checks NLINK optical links (CFEB/DCFEB/GEM) for frame-marker K-chars and cross-link alignment.
//  Per-link debounce: a link is declared lost only after err_thresh consecutive bad frames; per-link saturating error counters.

---
 rtl/csc_sync_pkg.sv | 20 ++
 rtl/csc_link_sync_chk.sv | 79 +++++++
 rtl/csc_link_sync_mon.sv | 133 +++++++++++++
 tb/tb_csc_link_sync_mon.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/csc_sync_pkg.sv
// Shared constants, FSM states and K-char helper
// for the CSC optical link sync monitor.
package csc_sync_pkg;

  localparam logic [7:0] K_IDLE = 8'hBC;
  localparam logic [7:0] K_BC0  = 8'hFC;

  typedef enum logic [1:0] {
    S_WAIT_DONE = 2'd0,
    S_DELAY     = 2'd1,
    S_MON       = 2'd2
  } state_e;

  function automatic logic is_frame_kchar(
    input logic [7:0] k
  );
    return (k == K_IDLE) || (k == K_BC0);
  endfunction

endpackage

// File: rtl/csc_link_sync_chk.sv
// Per-link checker: link_good settle pipeline, bad-frame
// debounce with latched lost flag, saturating error counter.
// Ports: clk_i/rst_ni, mon_i (FSM in S_MON), clr_i (resync or
//  unlock), cnt_clr_i, en_i, good_i, kchar_i, thresh_i ->
//  skip_o, bad_o, lost_o, cnt_o.
module csc_link_sync_chk
  import csc_sync_pkg::*;
#(
  parameter int KW   = 8,
  parameter int CNTW = 16
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            mon_i,
  input  logic            clr_i,
  input  logic            cnt_clr_i,
  input  logic            en_i,
  input  logic            good_i,
  input  logic [KW-1:0]   kchar_i,
  input  logic [3:0]      thresh_i,
  output logic            skip_o,
  output logic            bad_o,
  output logic            lost_o,
  output logic [CNTW-1:0] cnt_o
);

  logic            lg1_q, lg2_q;
  logic [3:0]      cb_q, cb_d, cb_inc, thr;
  logic            lost_q, lost_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic            valid, good_frm;

  // a link is only trusted once link_good has been up
  // for two full cycles
  assign skip_o   = !en_i | !good_i | !lg2_q;
  assign valid    = is_frame_kchar(8'(kchar_i));
  assign bad_o    = mon_i & !skip_o & !valid;
  assign good_frm = mon_i & !skip_o & valid;
  assign thr      = (thresh_i == 4'd0) ? 4'd1 : thresh_i;
  assign cb_inc   = (cb_q == 4'hF) ? cb_q : cb_q + 4'd1;

  always_comb begin
    cb_d   = cb_q;
    lost_d = lost_q;
    cnt_d  = cnt_q;
    if (bad_o) begin
      cb_d = cb_inc;
      if (cb_inc >= thr) lost_d = 1'b1;
      if (cnt_q != '1) cnt_d = cnt_q + CNTW'(1);
    end else if (good_frm) begin
      cb_d = 4'd0;
    end
    if (clr_i) begin
      cb_d   = 4'd0;
      lost_d = 1'b0;
    end
    if (cnt_clr_i) cnt_d = '0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lg1_q  <= 1'b0;
      lg2_q  <= 1'b0;
      cb_q   <= 4'd0;
      lost_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      lg1_q  <= good_i;
      lg2_q  <= lg1_q;
      cb_q   <= cb_d;
      lost_q <= lost_d;
      cnt_q  <= cnt_d;
    end
  end

  assign lost_o = lost_q;
  assign cnt_o  = cnt_q;

endmodule

// File: rtl/csc_link_sync_mon.sv
// Multi-link frame-marker sync monitor: arm FSM, per-link
// checkers, cross-link K-char compare and status reduction.
// Ports: clock/global_reset_n, clk_lock, ttc_resync, kchar,
//  fiber_enable, link_good, sync_done, sync_dly, err_thresh,
//  cnt_clear -> links_synced, links_lostsync, link_lost,
//  desync, link_err_cnt.
module csc_link_sync_mon
  import csc_sync_pkg::*;
#(
  parameter int NLINK = 7,
  parameter int KW    = 8,
  parameter int CNTW  = 16
) (
  input  logic                  clock,
  input  logic                  global_reset_n,
  input  logic                  clk_lock,
  input  logic                  ttc_resync,
  input  logic [NLINK*KW-1:0]   kchar,
  input  logic [NLINK-1:0]      fiber_enable,
  input  logic [NLINK-1:0]      link_good,
  input  logic [NLINK-1:0]      sync_done,
  input  logic [3:0]            sync_dly,
  input  logic [3:0]            err_thresh,
  input  logic                  cnt_clear,
  output logic                  links_synced,
  output logic                  links_lostsync,
  output logic [NLINK-1:0]      link_lost,
  output logic                  desync,
  output logic [NLINK*CNTW-1:0] link_err_cnt
);

  state_e         state_q, state_d;
  logic [3:0]     dly_q, dly_d;
  logic           clr, mon;
  logic [NLINK-1:0] skip, bad;
  logic           seen, diff, mismatch;
  logic [KW-1:0]  kref;
  logic           synced_q, desync_q, dlatch_q;

  assign clr = ttc_resync | !clk_lock;
  assign mon = (state_q == S_MON);

  always_comb begin
    state_d = state_q;
    dly_d   = dly_q;
    unique case (state_q)
      S_WAIT_DONE: begin
        if (&(sync_done | ~fiber_enable)) begin
          state_d = S_DELAY;
          dly_d   = 4'd0;
        end
      end
      S_DELAY: begin
        if (dly_q >= sync_dly) state_d = S_MON;
        else dly_d = dly_q + 4'd1;
      end
      S_MON: ;
      default: state_d = S_WAIT_DONE;
    endcase
    if (clr) begin
      state_d = S_WAIT_DONE;
      dly_d   = 4'd0;
    end
  end

  for (genvar i = 0; i < NLINK; i++) begin : g_lnk
    csc_link_sync_chk #(
      .KW   (KW),
      .CNTW (CNTW)
    ) u_chk (
      .clk_i     (clock),
      .rst_ni    (global_reset_n),
      .mon_i     (mon),
      .clr_i     (clr),
      .cnt_clr_i (cnt_clear),
      .en_i      (fiber_enable[i]),
      .good_i    (link_good[i]),
      .kchar_i   (kchar[i*KW +: KW]),
      .thresh_i  (err_thresh),
      .skip_o    (skip[i]),
      .bad_o     (bad[i]),
      .lost_o    (link_lost[i]),
      .cnt_o     (link_err_cnt[i*CNTW +: CNTW])
    );
  end

  // first checked link is the reference; any other checked
  // link differing from it is a mismatch, so a lone link
  // can never mismatch
  always_comb begin
    seen = 1'b0;
    diff = 1'b0;
    kref = '0;
    for (int i = 0; i < NLINK; i++) begin
      if (!skip[i]) begin
        if (!seen) begin
          seen = 1'b1;
          kref = kchar[i*KW +: KW];
        end else if (kchar[i*KW +: KW] != kref) begin
          diff = 1'b1;
        end
      end
    end
    mismatch = mon & diff;
  end

  always_ff @(posedge clock or negedge global_reset_n) begin
    if (!global_reset_n) begin
      state_q  <= S_WAIT_DONE;
      dly_q    <= 4'd0;
      synced_q <= 1'b1;
      desync_q <= 1'b0;
      dlatch_q <= 1'b0;
    end else begin
      state_q <= state_d;
      dly_q   <= dly_d;
      if (clr) begin
        synced_q <= 1'b1;
        desync_q <= 1'b0;
        dlatch_q <= 1'b0;
      end else begin
        synced_q <= mon ? (~|bad & ~mismatch) : 1'b1;
        desync_q <= mismatch;
        dlatch_q <= dlatch_q | mismatch;
      end
    end
  end

  assign links_synced   = synced_q;
  assign desync         = desync_q;
  assign links_lostsync = (|link_lost) | dlatch_q;

endmodule

// File: tb/tb_csc_link_sync_mon.sv
// Scoreboard bench for csc_link_sync_mon: stimulus queues
// hand-computed expectations, a monitor pops and compares.
module tb_csc_link_sync_mon;

  logic         clock = 1'b0;
  logic         global_reset_n;
  logic         clk_lock, ttc_resync, cnt_clear;
  logic [55:0]  kchar;
  logic [6:0]   fiber_enable, link_good, sync_done;
  logic [3:0]   sync_dly, err_thresh;
  logic         links_synced, links_lostsync, desync;
  logic [6:0]   link_lost;
  logic [111:0] link_err_cnt;

  int nchk = 0;
  int nerr = 0;

  localparam int M_SY = 1;
  localparam int M_LS = 2;
  localparam int M_LL = 4;
  localparam int M_DS = 8;
  localparam int M_CN = 16;
  localparam int ALL  = 31;

  typedef struct {
    string       nm;
    int          msk;
    bit          sy;
    bit          ls;
    logic [6:0]  ll;
    bit          ds;
    int          ci;
    logic [15:0] cv;
  } exp_t;

  exp_t q[$];

  csc_link_sync_mon dut (
    .clock          (clock),
    .global_reset_n (global_reset_n),
    .clk_lock       (clk_lock),
    .ttc_resync     (ttc_resync),
    .kchar          (kchar),
    .fiber_enable   (fiber_enable),
    .link_good      (link_good),
    .sync_done      (sync_done),
    .sync_dly       (sync_dly),
    .err_thresh     (err_thresh),
    .cnt_clear      (cnt_clear),
    .links_synced   (links_synced),
    .links_lostsync (links_lostsync),
    .link_lost      (link_lost),
    .desync         (desync),
    .link_err_cnt   (link_err_cnt)
  );

  always #5 clock = ~clock;

  task automatic cmp(string nm, logic [31:0] act,
                     logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  always @(posedge clock) begin
    #1;
    if (q.size() != 0) begin
      exp_t e;
      e = q.pop_front();
      if ((e.msk & M_SY) != 0)
        cmp({e.nm, ".synced"}, 32'(links_synced), 32'(e.sy));
      if ((e.msk & M_LS) != 0)
        cmp({e.nm, ".lostsync"}, 32'(links_lostsync),
            32'(e.ls));
      if ((e.msk & M_LL) != 0)
        cmp({e.nm, ".lost"}, 32'(link_lost), 32'(e.ll));
      if ((e.msk & M_DS) != 0)
        cmp({e.nm, ".desync"}, 32'(desync), 32'(e.ds));
      if ((e.msk & M_CN) != 0)
        cmp({e.nm, ".cnt"},
            32'(link_err_cnt[e.ci*16 +: 16]), 32'(e.cv));
    end
  end

  task automatic step(string nm, int msk, bit sy, bit ls,
                      logic [6:0] ll, bit ds, int ci,
                      logic [15:0] cv);
    exp_t e;
    e.nm  = nm;
    e.msk = msk;
    e.sy  = sy;
    e.ls  = ls;
    e.ll  = ll;
    e.ds  = ds;
    e.ci  = ci;
    e.cv  = cv;
    q.push_back(e);
    @(posedge clock);
    #2;
  endtask

  task automatic idle(int n);
    repeat (n) @(posedge clock);
    #2;
  endtask

  task automatic setk(int i, logic [7:0] v);
    kchar[i*8 +: 8] = v;
  endtask

  task automatic chk_reset(string nm);
    cmp({nm, ".synced"}, 32'(links_synced), 32'd1);
    cmp({nm, ".lostsync"}, 32'(links_lostsync), 32'd0);
    cmp({nm, ".lost"}, 32'(link_lost), 32'd0);
    cmp({nm, ".desync"}, 32'(desync), 32'd0);
    cmp({nm, ".cnt"}, 32'(|link_err_cnt), 32'd0);
  endtask

  initial begin
    global_reset_n = 1'b0;
    clk_lock       = 1'b1;
    ttc_resync     = 1'b0;
    cnt_clear      = 1'b0;
    kchar          = {7{8'hBC}};
    fiber_enable   = 7'h7F;
    link_good      = 7'h7F;
    sync_done      = 7'h00;
    sync_dly       = 4'd3;
    err_thresh     = 4'd3;
    #12;
    chk_reset("rst");
    global_reset_n = 1'b1;

    // arm with a mismatch probe to see exactly when S_MON starts
    sync_done = 7'h7F;
    setk(1, 8'hFC);
    for (int i = 0; i < 5; i++)
      step("t1.arm", M_SY | M_DS | M_LS, 1, 0, 0, 0, 0, 0);
    step("t1.mon", M_SY | M_DS | M_LS, 0, 1, 0, 1, 0, 0);
    setk(1, 8'hBC);
    step("t1.idle", ALL, 1, 1, 7'h00, 0, 1, 16'd0);
    ttc_resync   = 1'b1;
    fiber_enable = 7'b0000100;
    step("t1.rsync", M_LS | M_LL | M_DS, 1, 0, 0, 0, 0, 0);
    ttc_resync = 1'b0;
    sync_dly   = 4'd0;
    step("t2.arm", M_SY, 1, 0, 0, 0, 0, 0);
    step("t2.arm", M_SY, 1, 0, 0, 0, 0, 0);

    // single enabled link: bad frames but never a mismatch
    setk(2, 8'h55);
    step("t2.bad1", ALL, 0, 0, 7'h00, 0, 2, 16'd1);
    step("t2.bad2", ALL, 0, 0, 7'h00, 0, 2, 16'd2);
    setk(2, 8'hBC);
    step("t2.good", ALL, 1, 0, 7'h00, 0, 2, 16'd2);
    setk(2, 8'h55);
    step("t2.bad3", ALL, 0, 0, 7'h00, 0, 2, 16'd3);
    step("t2.bad4", ALL, 0, 0, 7'h00, 0, 2, 16'd4);
    step("t2.bad5", ALL, 0, 1, 7'h04, 0, 2, 16'd5);
    setk(2, 8'hBC);
    step("t2.hold", ALL, 1, 1, 7'h04, 0, 2, 16'd5);

    fiber_enable = 7'h7F;
    setk(1, 8'hFC);
    step("t3.dsync", ALL, 0, 1, 7'h04, 1, 1, 16'd0);
    setk(1, 8'hBC);
    step("t3.clean", ALL, 1, 1, 7'h04, 0, 1, 16'd0);
    err_thresh = 4'd0;
    setk(5, 8'h00);
    step("t3.thr0", ALL, 0, 1, 7'h24, 1, 5, 16'd1);
    setk(5, 8'hBC);
    err_thresh = 4'd3;
    step("t3.rec", M_SY | M_DS, 1, 0, 0, 0, 0, 0);

    ttc_resync   = 1'b1;
    link_good[3] = 1'b0;
    setk(3, 8'h55);
    step("t6.rsync", M_LS | M_LL | M_DS | M_CN,
         1, 0, 7'h00, 0, 2, 16'd5);
    ttc_resync   = 1'b0;
    fiber_enable = 7'b1101111;
    setk(4, 8'h00);
    step("t4.arm", M_SY, 1, 0, 0, 0, 0, 0);
    step("t4.arm", M_SY, 1, 0, 0, 0, 0, 0);
    link_good[3] = 1'b1;
    step("t4.skip1", ALL, 1, 0, 7'h00, 0, 3, 16'd0);
    step("t4.skip2", ALL, 1, 0, 7'h00, 0, 3, 16'd0);
    step("t4.chk", ALL, 0, 1, 7'h00, 1, 3, 16'd1);
    setk(3, 8'hBC);
    step("t4.dis", ALL, 1, 1, 7'h00, 0, 4, 16'd0);
    fiber_enable = 7'h7F;
    setk(4, 8'hBC);

    setk(1, 8'h55);
    step("t5.first", M_CN, 0, 0, 0, 0, 1, 16'd1);
    idle(65534);
    step("t5.sat", M_CN, 0, 0, 0, 0, 1, 16'hFFFF);
    step("t5.hold", M_CN, 0, 0, 0, 0, 1, 16'hFFFF);
    cnt_clear = 1'b1;
    step("t5.clr", M_CN, 0, 0, 0, 0, 1, 16'd0);
    cnt_clear = 1'b0;
    step("t5.clr2", M_CN, 0, 0, 0, 0, 2, 16'd0);
    step("t5.inc", M_CN, 0, 0, 0, 0, 1, 16'd2);

    setk(1, 8'hBC);
    ttc_resync = 1'b1;
    step("t6.rs2", M_LL | M_CN, 0, 0, 7'h00, 0, 1, 16'd2);
    ttc_resync = 1'b0;
    sync_dly   = 4'd15;
    step("t6.dly", M_SY, 1, 0, 0, 0, 0, 0);
    step("t6.dly", M_SY, 1, 0, 0, 0, 0, 0);
    #3;
    global_reset_n = 1'b0;
    #1;
    chk_reset("t6.arst");
    #6;
    global_reset_n = 1'b1;
    idle(2);

    $display("CHECKS %0d ERRORS %0d", nchk, nerr);
    $finish;
  end

endmodule
